// File: rtl/gen_lane_sched_pkg.sv
// gen_lane_sched_pkg: shared types and helpers for the lane scheduler.
//   state_e - scheduler FSM states (run / drain / done)
//   tag_t   - per-issue tag carried alongside the shared lane
//   rr_pick - round-robin one-hot pick starting at a pointer
package gen_lane_sched_pkg;

  // Sized for the largest supported requester count (16).
  localparam int unsigned MaxReq = 16;
  localparam int unsigned IdW    = 4;

  typedef enum logic [1:0] {
    StRun,
    StDrain,
    StDone
  } state_e;

  typedef struct packed {
    logic           vld;
    logic [IdW-1:0] id;
  } tag_t;

  // First asserted bit of valid at or above ptr, wrapping modulo num_req.
  function automatic logic [MaxReq-1:0] rr_pick(input logic [MaxReq-1:0] valid,
                                                input logic [IdW-1:0]    ptr,
                                                input int unsigned       num_req);
    logic [MaxReq-1:0] grant;
    logic [IdW-1:0]    idx;
    logic              found;
    grant = '0;
    idx   = '0;
    found = 1'b0;
    for (int unsigned i = 0; i < MaxReq; i++) begin
      if (i < num_req && !found) begin
        idx = IdW'((32'(ptr) + i) % num_req);
        if (valid[idx]) begin
          grant[idx] = 1'b1;
          found      = 1'b1;
        end
      end
    end
    return grant;
  endfunction

endpackage

// File: rtl/gen_lane_sched_if.sv
// gen_lane_sched_if: request / lane / response signals of the lane scheduler.
//   master - requester and lane side (drives req_valid, req_data, lane_y)
//   slave  - scheduler side (drives req_ready, lane_a, lane_a_valid, resp_*)
interface gen_lane_sched_if #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned DATA_W  = 1
);
  logic [NUM_REQ-1:0]        req_valid;
  logic [NUM_REQ*DATA_W-1:0] req_data;
  logic [NUM_REQ-1:0]        req_ready;
  logic [DATA_W-1:0]         lane_a;
  logic                      lane_a_valid;
  logic [DATA_W-1:0]         lane_y;
  logic [NUM_REQ-1:0]        resp_valid;
  logic [DATA_W-1:0]         resp_data;

  modport master (
    output req_valid, req_data, lane_y,
    input  req_ready, lane_a, lane_a_valid, resp_valid, resp_data
  );

  modport slave (
    input  req_valid, req_data, lane_y,
    output req_ready, lane_a, lane_a_valid, resp_valid, resp_data
  );
endinterface

// File: rtl/gen_lane_sched_rr.sv
// gen_lane_sched_rr: round-robin picker with its rotating pointer.
//   clk, rst   - clock, async active-high reset (pointer -> 0)
//   req_valid  - per-requester valid
//   enable     - allow a grant this cycle
//   grant      - one-hot grant (combinational)
//   grant_vld  - any grant this cycle
//   grant_id   - index of the granted requester
module gen_lane_sched_rr
  import gen_lane_sched_pkg::*;
#(
  parameter int unsigned NUM_REQ = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_REQ-1:0] req_valid,
  input  logic               enable,
  output logic [NUM_REQ-1:0] grant,
  output logic               grant_vld,
  output logic [IdW-1:0]     grant_id
);

  logic [IdW-1:0] ptr_q, ptr_d;

  always_comb begin
    grant = '0;
    if (enable) grant = NUM_REQ'(rr_pick(MaxReq'(req_valid), ptr_q, NUM_REQ));
    grant_vld = |grant;
    grant_id  = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (grant[i]) grant_id = IdW'(i);
    end
  end

  // Pointer moves just past the winner so it has lowest priority next time.
  always_comb begin
    ptr_d = ptr_q;
    if (grant_vld) begin
      ptr_d = (grant_id == IdW'(NUM_REQ - 1)) ? '0 : grant_id + IdW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) ptr_q <= '0;
    else     ptr_q <= ptr_d;
  end

endmodule

// File: rtl/gen_lane_sched.sv
// gen_lane_sched: round-robin sharing of one fixed-latency lane among NUM_REQ requesters.
//   clk, rst    - clock, async active-high reset
//   bus         - gen_lane_sched_if.slave: req_valid/req_data/req_ready handshake,
//                 lane_a/lane_a_valid to the lane, lane_y back, resp_valid/resp_data out
//   flush       - level-sampled drain request
//   flush_done  - one-cycle pulse when the drain completes
//   busy        - transfers in flight or not in the run state
// Optional (macro GEN_LANE_SCHED_STATS_EN):
//   stats_clr   - synchronous clear of the grant counters
//   grant_cnt   - saturating 16-bit grant count per requester
module gen_lane_sched
  import gen_lane_sched_pkg::*;
#(
  parameter int unsigned NUM_REQ  = 4,
  parameter int unsigned DATA_W   = 1,
  parameter int unsigned LANE_LAT = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  gen_lane_sched_if.slave       bus,
  input  logic                  flush,
  output logic                  flush_done,
  output logic                  busy
`ifdef GEN_LANE_SCHED_STATS_EN
  ,
  input  logic                  stats_clr,
  output logic [NUM_REQ*16-1:0] grant_cnt
`endif
);

  localparam int unsigned CntW = $clog2(LANE_LAT + 3);

  state_e             state_q, state_d;
  logic [NUM_REQ-1:0] grant;
  logic               grant_vld;
  logic [IdW-1:0]     grant_id;
  logic [DATA_W-1:0]  sel_data;
  logic [DATA_W-1:0]  lane_a_q, resp_data_q;
  logic [NUM_REQ-1:0] resp_valid_q;
  logic [CntW-1:0]    inflight_q, inflight_d;
  logic               resp_load;

  // tag_q[0] travels with lane_a; tag_q[LANE_LAT] lines up with lane_y.
  tag_t tag_q [LANE_LAT+1];

  gen_lane_sched_rr #(
    .NUM_REQ(NUM_REQ)
  ) u_rr (
    .clk      (clk),
    .rst      (rst),
    .req_valid(bus.req_valid),
    .enable   ((state_q == StRun) && !flush),
    .grant    (grant),
    .grant_vld(grant_vld),
    .grant_id (grant_id)
  );

  assign bus.req_ready    = grant;
  assign bus.lane_a       = lane_a_q;
  assign bus.lane_a_valid = tag_q[0].vld;
  assign bus.resp_valid   = resp_valid_q;
  assign bus.resp_data    = resp_data_q;
  assign resp_load        = tag_q[LANE_LAT].vld;

  always_comb begin
    sel_data = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (grant[i]) sel_data = bus.req_data[i*DATA_W +: DATA_W];
    end
  end

  always_comb begin
    inflight_d = inflight_q;
    unique case ({grant_vld, resp_load})
      2'b10:   inflight_d = inflight_q + CntW'(1);
      2'b01:   inflight_d = inflight_q - CntW'(1);
      default: inflight_d = inflight_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lane_a_q     <= '0;
      resp_valid_q <= '0;
      resp_data_q  <= '0;
      inflight_q   <= '0;
      for (int unsigned i = 0; i <= LANE_LAT; i++) tag_q[i] <= '0;
    end else begin
      if (grant_vld) lane_a_q <= sel_data;
      tag_q[0] <= '{vld: grant_vld, id: grant_id};
      for (int unsigned i = 1; i <= LANE_LAT; i++) tag_q[i] <= tag_q[i-1];
      resp_valid_q <= resp_load ? (NUM_REQ'(1) << tag_q[LANE_LAT].id) : '0;
      if (resp_load) resp_data_q <= bus.lane_y;
      inflight_q <= inflight_d;
    end
  end

  // FSM: state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= StRun;
    else     state_q <= state_d;
  end

  // FSM: next state
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StRun:   if (flush) state_d = StDrain;
      // Issues are blocked from the flush cycle on, so the count covers everything pending.
      StDrain: if (inflight_q == '0) state_d = StDone;
      StDone:  state_d = StRun;
      default: state_d = StRun;
    endcase
  end

  // FSM: outputs
  always_comb begin
    flush_done = (state_q == StDone);
    busy       = (inflight_q != '0) || (state_q != StRun);
  end

`ifdef GEN_LANE_SCHED_STATS_EN
  logic [15:0] cnt_q [NUM_REQ];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < NUM_REQ; i++) cnt_q[i] <= '0;
    end else begin
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
        if (stats_clr)                         cnt_q[i] <= '0;
        else if (grant[i] && cnt_q[i] != '1)   cnt_q[i] <= cnt_q[i] + 16'd1;
      end
    end
  end

  always_comb begin
    grant_cnt = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) grant_cnt[i*16 +: 16] = cnt_q[i];
  end
`else
  // Grant statistics not built.
`endif

endmodule

// File: tb/tb_gen_lane_sched.sv
// tb_gen_lane_sched: directed scenarios plus randomized traffic, flushes and resets,
// checked every cycle against a transaction-level model (grant queue with due cycles).
module tb_gen_lane_sched;

  localparam int unsigned NR = 4;
  localparam int unsigned DW = 4;
  localparam int unsigned LL = 2;

  logic clk = 1'b0;
  logic rst;
  logic flush;
  logic flush_done;
  logic busy;
`ifdef GEN_LANE_SCHED_STATS_EN
  logic              stats_clr = 1'b0;
  logic [NR*16-1:0]  grant_cnt;
`endif

  always #5 clk = ~clk;

  gen_lane_sched_if #(.NUM_REQ(NR), .DATA_W(DW)) bus ();

  gen_lane_sched #(
    .NUM_REQ (NR),
    .DATA_W  (DW),
    .LANE_LAT(LL)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus.slave),
    .flush     (flush),
    .flush_done(flush_done),
    .busy      (busy)
`ifdef GEN_LANE_SCHED_STATS_EN
    ,
    .stats_clr (stats_clr),
    .grant_cnt (grant_cnt)
`endif
  );

  // Shared lane stand-in: y = f(a), LL cycles later.
  function automatic logic [DW-1:0] lane_f(input logic [DW-1:0] a);
    return DW'(32'(a) * 3 + 1);
  endfunction

  logic [DW-1:0] lpipe [LL];
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < LL; i++) lpipe[i] <= '0;
    end else begin
      lpipe[0] <= lane_f(bus.lane_a);
      for (int i = 1; i < LL; i++) lpipe[i] <= lpipe[i-1];
    end
  end
  assign bus.lane_y = lpipe[LL-1];

  // Reference model state
  typedef struct {
    int            id;
    logic [DW-1:0] y;
    int            due;
  } xfer_t;

  xfer_t         exp_q [$];
  int            cyc;
  int            mptr;
  int            blk_start;
  int            blk_end;
  int            prev_grant;
  logic [DW-1:0] prev_data;
  logic [DW-1:0] last_y;
  int            n_checks;
  int            n_fail;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic model_reset();
    exp_q.delete();
    mptr       = 0;
    blk_start  = -1;
    blk_end    = -1;
    prev_grant = -1;
    prev_data  = '0;
    last_y     = '0;
  endtask

  task automatic check_reset_outputs();
    check_val("rst_lane_a",       bus.lane_a,       0);
    check_val("rst_lane_a_valid", bus.lane_a_valid, 0);
    check_val("rst_resp_valid",   bus.resp_valid,   0);
    check_val("rst_resp_data",    bus.resp_data,    0);
    check_val("rst_flush_done",   flush_done,       0);
    check_val("rst_busy",         busy,             0);
    check_val("rst_req_ready",    bus.req_ready,    0);
  endtask

  // One clock cycle: drive inputs, predict, compare.
  task automatic step(input logic [NR-1:0] v, input logic [NR*DW-1:0] d, input logic f);
    int            g;
    bit            run;
    bit            exp_busy;
    logic [NR-1:0] exp_ready;
    logic [NR-1:0] exp_rv;
    logic [DW-1:0] exp_rd;
    @(posedge clk);
    cyc++;
    #1;
    bus.req_valid = v;
    bus.req_data  = d;
    flush         = f;

    run = (cyc > blk_end);
    g   = -1;
    if (run && !f) begin
      for (int i = 0; i < int'(NR); i++) begin
        int j;
        j = (mptr + i) % NR;
        if (v[j] && g < 0) g = j;
      end
    end
    exp_ready = (g >= 0) ? (NR'(1) << g) : '0;

    exp_rv = '0;
    exp_rd = last_y;
    if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
      exp_rv = NR'(1) << exp_q[0].id;
      exp_rd = exp_q[0].y;
      last_y = exp_q[0].y;
      void'(exp_q.pop_front());
    end
    exp_busy = (exp_q.size() > 0) || (cyc > blk_start && cyc <= blk_end);

    if (run && f) begin
      blk_start = cyc;
      blk_end   = cyc + 2;
      if (exp_q.size() > 0 && exp_q[$].due + 1 > blk_end) blk_end = exp_q[$].due + 1;
    end

    @(negedge clk);
    check_val("req_ready",    bus.req_ready,    exp_ready);
    check_val("resp_valid",   bus.resp_valid,   exp_rv);
    check_val("resp_data",    bus.resp_data,    exp_rd);
    check_val("flush_done",   flush_done,       (cyc == blk_end) ? 1 : 0);
    check_val("busy",         busy,             exp_busy ? 1 : 0);
    check_val("lane_a_valid", bus.lane_a_valid, (prev_grant >= 0) ? 1 : 0);
    if (prev_grant >= 0) check_val("lane_a", bus.lane_a, prev_data);

    if (g >= 0) begin
      exp_q.push_back('{id: g, y: lane_f(d[g*DW +: DW]), due: cyc + int'(LL) + 2});
      mptr      = (g + 1) % NR;
      prev_data = d[g*DW +: DW];
    end
    prev_grant = g;
  endtask

  // Asynchronous reset pulse between clock edges.
  task automatic do_reset();
    @(posedge clk);
    cyc++;
    #2;
    rst           = 1'b1;
    bus.req_valid = '0;
    flush         = 1'b0;
    #1;
    check_reset_outputs();
    model_reset();
    @(posedge clk);
    cyc++;
    #1;
    rst = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step('0, '0, 1'b0);
  endtask

  initial begin
    n_checks      = 0;
    n_fail        = 0;
    cyc           = 0;
    rst           = 1'b1;
    flush         = 1'b0;
    bus.req_valid = '0;
    bus.req_data  = '0;
    model_reset();
    @(posedge clk);
    @(posedge clk);
    cyc = 2;
    #1;
    check_reset_outputs();
    rst = 1'b0;

    // All requesters valid for 8 cycles: 0,1,2,3,0,1,2,3
    for (int i = 0; i < 8; i++) step('1, 16'h7c3a + 16'(i * 16'h1111), 1'b0);
    idle(6);

    // Single request from requester 2 with operand 1
    step(4'b0100, 16'h0100, 1'b0);
    idle(5);

    // Fairness: grant 3, then 0 and 2 valid -> 0, then 2
    step(4'b1000, 16'h9000, 1'b0);
    step(4'b0101, 16'h0a0b, 1'b0);
    step(4'b0101, 16'h0c0d, 1'b0);
    idle(5);

    // Flush with three in flight
    step('1, 16'h1234, 1'b0);
    step('1, 16'h5678, 1'b0);
    step('1, 16'h9abc, 1'b0);
    step('1, 16'hdef0, 1'b1);
    idle(8);

    // Flush with nothing in flight
    step('0, '0, 1'b1);
    idle(4);

    // Reset shortly after two issues
    step('1, 16'h4321, 1'b0);
    step('1, 16'h8765, 1'b0);
    do_reset();
    idle(10);
    step('1, 16'hfedc, 1'b0);
    idle(5);

    // Randomized traffic with occasional flush and reset
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 149) == 0) begin
        do_reset();
      end else begin
        step(NR'($urandom), 16'($urandom), ($urandom_range(0, 19) == 0));
      end
    end
    idle(8);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/gen_lane_sched.md
Name: gen_lane_sched

Overview:
- Round-robin scheduler that shares one fixed-latency single-input/single-output processing lane (a -> y) among NUM_REQ requesters.
- Replaces per-requester generate-loop replication of the lane when area matters.
- Sits between the requester generate block and the single shared lane instance.
- Tags each issued transfer and routes the lane result back to the originating requester; provides a flush/drain sequence.

Parameters:
- NUM_REQ, 4, number of requesters (2..16).
- DATA_W, 1, width of a and y.
- LANE_LAT, 2, lane latency in cycles from lane_a_valid to the matching lane_y (1..8).

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- req_valid  in  NUM_REQ  per-requester request valid.
- req_data  in  NUM_REQ*DATA_W  per-requester operand; slice i belongs to requester i.
- req_ready  out  NUM_REQ  one-hot grant, combinational.
- lane_a  out  DATA_W  registered operand to the shared lane.
- lane_a_valid  out  1  registered issue strobe to the lane.
- lane_y  in  DATA_W  lane result, valid exactly LANE_LAT cycles after lane_a_valid.
- resp_valid  out  NUM_REQ  registered one-hot response strobe.
- resp_data  out  DATA_W  registered result, common to all requesters.
- flush  in  1  request a drain; level-sampled.
- flush_done  out  1  one-cycle pulse when the drain completes.
- busy  out  1  high while any transfer is in flight or the FSM is not in RUN.

Behaviour:
- Reset values (async, rst=1): lane_a=0, lane_a_valid=0, resp_valid=0, resp_data=0, flush_done=0, busy=0, rr pointer=0, FSM=RUN, tag pipe cleared, in-flight count=0.
- Arbitration:
  - In RUN with flush=0, grant the first asserted req_valid searching from ptr upward, wrapping modulo NUM_REQ.
  - req_ready[g]=1 only for the granted index; one grant per cycle maximum.
  - req_ready depends combinationally on req_valid; requesters must not make req_valid depend on req_ready.
  - A transfer completes on req_valid & req_ready.
  - After a grant to g, ptr <= (g+1) mod NUM_REQ. With no grant, ptr holds.
- Timing, for a grant at cycle t:
  - lane_a = req_data slice g and lane_a_valid=1 at t+1.
  - The tag (g, valid) travels a LANE_LAT-deep shift pipe aligned with the lane.
  - lane_y is captured at t+1+LANE_LAT.
  - resp_valid[g]=1 and resp_data=lane_y at t+2+LANE_LAT; total latency LANE_LAT+2.
  - resp_valid is a one-cycle pulse. There is no response backpressure.
  - resp_data holds its last value when resp_valid=0.
- Throughput: one issue per cycle sustained; results return in issue order.
- In-flight counter:
  - Width clog2(LANE_LAT+3).
  - +1 on issue, -1 on response register load; both in the same cycle means no change.
  - Never exceeds LANE_LAT+2.
- FSM states:
  - RUN: normal operation. flush=1 -> DRAIN. The grant is suppressed in the cycle flush is sampled high.
  - DRAIN: no grants; req_ready=0. Go to DONE when in-flight count==0 and no issue is pending. flush is ignored in this state.
  - DONE: flush_done=1 for exactly one cycle, then RUN unconditionally.
  - A flush in RUN with zero in flight still goes RUN->DRAIN->DONE, so flush_done appears 2 cycles after flush.
- busy = (in-flight != 0) | (FSM != RUN).
- Simultaneous events:
  - flush and req_valid in the same RUN cycle: no grant.
  - Issue and response in the same cycle: both are handled.
- Reset mid-operation: all in-flight tags are discarded; no resp_valid for them after reset release. The lane is assumed flushed by its own reset.

Optional Feature:
- Macro GEN_LANE_SCHED_STATS_EN.
- When defined:
  - Adds output grant_cnt (NUM_REQ*16 bits), one saturating 16-bit counter per requester, incremented on each grant.
  - Adds input stats_clr (1 bit), which synchronously zeroes all counters. If stats_clr and a grant occur in the same cycle, the clear wins.
  - Counters reset to 0.
- When undefined: the ports and logic are absent; behaviour is otherwise identical.

Decomposition:
- Package gen_lane_sched_pkg holds:
  - FSM state enum {RUN, DRAIN, DONE}.
  - Tag struct {logic vld; logic [clog2(NUM_REQ)-1:0] id}.
  - Function rr_pick(valid, ptr), returning the one-hot grant.
- One natural sub-module: gen_lane_sched_rr, the combinational/registered round-robin picker plus pointer.
- FSM, tag pipe and counters stay in the top module.

Test Plan:
- Single request, NUM_REQ=4, LANE_LAT=2: req_valid=4'b0100 with data 1 at t=0 -> req_ready=4'b0100 at t=0, lane_a_valid at t=1, resp_valid=4'b0100 and resp_data=lane_y at t=4.
- All four requesters valid continuously for 8 cycles -> grant order 0,1,2,3,0,1,2,3; 8 resp_valid pulses in the same order, 4 cycles after each grant.
- Pointer fairness: after a grant to 3, requesters 0 and 2 are valid -> grant 0; the next cycle -> grant 2.
- flush asserted for 1 cycle while 3 transfers are in flight -> no grants from that cycle onward; all 3 responses arrive; flush_done pulses once on the cycle after the last response; busy falls with it.
- flush with nothing in flight -> flush_done pulses exactly 2 cycles later; busy is high for those 2 cycles.
- rst pulse 1 cycle after two issues -> all outputs 0 immediately; no resp_valid during 10 cycles after release; the first grant after release goes to requester 0.
